led_shifter: RTL and testbench

LED_SHIFTER -- requirements
Module: led_shifter

---
 rtl/led_pkg.sv | 19 +
 rtl/led_bit_timer.sv | 31 +++
 rtl/led_shifter.sv | 146 ++++++++++++++
 tb/tb_led_shifter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared LED definitions: frame FSM states, default pattern width, counter sizing.
// Latency: n/a. Backpressure: n/a.
package led_pkg;

    localparam int LED_DATA_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_DONE  = 2'd3
    } led_state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_bit_timer.sv
// Half-period timer: one-cycle tick every DIV cycles while run is high.
// Latency: first tick DIV cycles after run rises. Backpressure: none, counter clears when run drops.
module led_bit_timer
    import led_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic CLOCK_IN,
    input  logic RESET,
    input  logic run,
    output logic tick
);

    localparam int CW = cnt_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_IN or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (!run || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/led_shifter.sv
// Serialises DATA_W-bit LED frames MSB first onto SCLK/SDO, then strobes LATCH.
// Latency: SHIFT starts the cycle after LOAD; frame lasts (2*DATA_W+1)*DIV+1 cycles.
// Backpressure: LOAD while BUSY is held as one pending word (latest wins), started right after DONE.
module led_shifter
    import led_pkg::*;
#(
    parameter int DATA_W = LED_DATA_W,
    parameter int DIV    = 4
) (
    input  logic              CLOCK_IN,
    input  logic              RESET,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              LOAD,
    output logic              BUSY,
    output logic              DONE,
    output logic              SCLK,
    output logic              SDO,
    output logic              LATCH
);

    localparam int BW = cnt_w(DATA_W + 1);
    localparam logic [BW-1:0] FIRST_BIT = BW'(DATA_W);
    localparam logic [BW-1:0] LAST_BIT  = BW'(1);

    led_state_t        state;
    led_state_t        state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] pend_word;
    logic              pend;
    logic [BW-1:0]     bit_cnt;
    logic              sclk_hi;
    logic              run;
    logic              tick;
    logic              restart;

    assign run     = (state == ST_SHIFT) || (state == ST_LATCH);
    // A LOAD in the DONE cycle is taken directly so it beats an older pending word.
    assign restart = (state == ST_DONE) && (pend || LOAD);

    led_bit_timer #(
        .DIV(DIV)
    ) u_bit_timer (
        .CLOCK_IN (CLOCK_IN),
        .RESET    (RESET),
        .run      (run),
        .tick     (tick)
    );

    always_ff @(posedge CLOCK_IN or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (LOAD) state_nxt = ST_SHIFT;
            ST_SHIFT: if (tick && sclk_hi && bit_cnt == LAST_BIT) state_nxt = ST_LATCH;
            ST_LATCH: if (tick) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = restart ? ST_SHIFT : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY  = 1'b0;
        DONE  = 1'b0;
        SCLK  = 1'b0;
        SDO   = 1'b0;
        LATCH = 1'b0;
        unique case (state)
            ST_IDLE: ;
            ST_SHIFT: begin
                BUSY = 1'b1;
                SCLK = sclk_hi;
                SDO  = shreg[DATA_W-1];
            end
            ST_LATCH: begin
                BUSY  = 1'b1;
                LATCH = 1'b1;
            end
            ST_DONE: begin
                BUSY = 1'b1;
                DONE = 1'b1;
            end
            default: ;
        endcase
    end

    // Shift datapath: SDO changes only when SCLK falls, i.e. at the end of a high half.
    always_ff @(posedge CLOCK_IN or posedge RESET) begin
        if (RESET) begin
            shreg   <= '0;
            bit_cnt <= '0;
            sclk_hi <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (LOAD) begin
                        shreg   <= DATA_IN;
                        bit_cnt <= FIRST_BIT;
                        sclk_hi <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (!sclk_hi) begin
                            sclk_hi <= 1'b1;
                        end else begin
                            sclk_hi <= 1'b0;
                            if (bit_cnt != LAST_BIT) begin
                                bit_cnt <= bit_cnt - 1'b1;
                                shreg   <= shreg << 1;
                            end
                        end
                    end
                end
                ST_LATCH: ;
                ST_DONE: begin
                    if (restart) begin
                        shreg   <= LOAD ? DATA_IN : pend_word;
                        bit_cnt <= FIRST_BIT;
                        sclk_hi <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_IN or posedge RESET) begin
        if (RESET) begin
            pend      <= 1'b0;
            pend_word <= '0;
        end else if (state == ST_DONE) begin
            pend <= 1'b0;
        end else if (state != ST_IDLE && LOAD) begin
            pend      <= 1'b1;
            pend_word <= DATA_IN;
        end
    end

endmodule

// File: tb/tb_led_shifter.sv
// Bench for led_shifter: DIV=4 and DIV=1 instances, expected frames queued at stimulus,
// compared by a monitor at each DONE.
module tb_led_shifter;

    localparam int W = 9;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din0;
    logic [W-1:0] din1;
    logic [1:0]   load;
    logic [1:0]   busy;
    logic [1:0]   done;
    logic [1:0]   sclk;
    logic [1:0]   sdo;
    logic [1:0]   latch;

    always #5 clk = ~clk;

    led_shifter #(.DATA_W(W), .DIV(4)) u_div4 (
        .CLOCK_IN (clk),
        .RESET    (rst),
        .DATA_IN  (din0),
        .LOAD     (load[0]),
        .BUSY     (busy[0]),
        .DONE     (done[0]),
        .SCLK     (sclk[0]),
        .SDO      (sdo[0]),
        .LATCH    (latch[0])
    );

    led_shifter #(.DATA_W(W), .DIV(1)) u_div1 (
        .CLOCK_IN (clk),
        .RESET    (rst),
        .DATA_IN  (din1),
        .LOAD     (load[1]),
        .BUSY     (busy[1]),
        .DONE     (done[1]),
        .SCLK     (sclk[1]),
        .SDO      (sdo[1]),
        .LATCH    (latch[1])
    );

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    logic [W-1:0] word [2];
    int           rises [2];
    int           latch_len [2];
    int           busy_len [2];
    int           run_len [2];
    int           last_run [2];
    int           done_cnt [2];
    logic [1:0]   sclk_prev = '0;
    logic [1:0]   latch_prev = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int d, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done[d]) seen = 1'b1;
        end
        check($sformatf("done_within_%0d_d%0d", budget, d), 32'(seen), 32'd1);
    endtask

    // Monitor: collects SDO at every SCLK rise and scores the frame on DONE.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int           div;
            int           qsz;
            logic [W-1:0] e;
            div = (d == 0) ? 4 : 1;
            if (rst) begin
                word[d] = '0; rises[d] = 0; latch_len[d] = 0;
                busy_len[d] = 0; run_len[d] = 0;
            end else begin
                if (sclk[d] && !sclk_prev[d]) begin
                    word[d] = {word[d][W-2:0], sdo[d]};
                    rises[d]++;
                end
                if (latch[d]) latch_len[d]++;
                if (busy[d]) begin
                    busy_len[d]++;
                    run_len[d]++;
                end else if (run_len[d] != 0) begin
                    last_run[d] = run_len[d];
                    run_len[d]  = 0;
                end
                if (done[d]) begin
                    qsz = (d == 0) ? exp_q0.size() : exp_q1.size();
                    check($sformatf("frame_expected_d%0d", d), 32'(qsz != 0), 32'd1);
                    if (qsz != 0) begin
                        e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check($sformatf("frame_word_d%0d", d), 32'(word[d]), 32'(e));
                    end
                    check($sformatf("sclk_rises_d%0d", d), rises[d], W);
                    check($sformatf("latch_len_d%0d", d), latch_len[d], div);
                    check($sformatf("latch_before_done_d%0d", d), 32'(latch_prev[d]), 32'd1);
                    check($sformatf("busy_len_d%0d", d), busy_len[d], (2 * W + 1) * div + 1);
                    done_cnt[d]++;
                    word[d] = '0; rises[d] = 0; latch_len[d] = 0; busy_len[d] = 0;
                end
            end
            sclk_prev[d]  = sclk[d];
            latch_prev[d] = latch[d];
        end
    end

    initial begin
        int   dstart;
        logic busy_seen;
        logic latch_seen;

        for (int d = 0; d < 2; d++) begin
            last_run[d] = 0;
            done_cnt[d] = 0;
        end
        rst  = 1'b1;
        load = '0;
        din0 = '0;
        din1 = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs_d0", 32'({busy[0], done[0], sclk[0], sdo[0], latch[0]}), 32'd0);
        check("reset_outputs_d1", 32'({busy[1], done[1], sclk[1], sdo[1], latch[1]}), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Single frame 9'h1A5.
        @(posedge clk); #1 din0 = 9'h1A5; load[0] = 1'b1; exp_q0.push_back(9'h1A5);
        @(posedge clk); #1 load[0] = 1'b0;
        check("entry_busy", 32'(busy[0]), 32'd1);
        check("entry_sclk", 32'(sclk[0]), 32'd0);
        check("entry_sdo",  32'(sdo[0]),  32'd1);
        wait_done(0, 100);
        @(negedge clk);
        check("idle_after_done", 32'(busy[0]), 32'd0);

        // Two requests mid-frame: only the latest is shifted next, without a gap.
        @(posedge clk); #1 din0 = 9'h055; load[0] = 1'b1;
        exp_q0.push_back(9'h055); exp_q0.push_back(9'h100);
        @(posedge clk); #1 load[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1 din0 = 9'h0FF; load[0] = 1'b1;
        @(posedge clk); #1 load[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1 din0 = 9'h100; load[0] = 1'b1;
        @(posedge clk); #1 load[0] = 1'b0; din0 = 9'h03C;
        wait_done(0, 100);
        @(negedge clk);
        check("pending_start_busy", 32'(busy[0]), 32'd1);
        check("pending_start_sclk", 32'(sclk[0]), 32'd0);
        check("pending_start_sdo",  32'(sdo[0]),  32'd1);
        wait_done(0, 100);
        repeat (3) @(negedge clk);
        check("pending_busy_run", last_run[0], 2 * 77);

        // Reset during the 5th bit aborts the frame.
        @(posedge clk); #1 din0 = 9'h0AA; load[0] = 1'b1;
        @(posedge clk); #1 load[0] = 1'b0;
        latch_seen = 1'b0;
        repeat (34) begin
            @(negedge clk);
            latch_seen |= latch[0];
        end
        check("abort_busy_before", 32'(busy[0]), 32'd1);
        check("abort_sclk_low_half", 32'(sclk[0]), 32'd0);
        #1 rst = 1'b1;
        #1 check("abort_outputs_zero",
                 32'({busy[0], done[0], sclk[0], sdo[0], latch[0]}), 32'd0);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        busy_seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            busy_seen  |= busy[0];
            latch_seen |= latch[0];
        end
        check("abort_busy_stays_low", 32'(busy_seen), 32'd0);
        check("abort_no_latch", 32'(latch_seen), 32'd0);

        // DIV=1: SCLK toggles every cycle.
        @(posedge clk); #1 din1 = 9'h1FF; load[1] = 1'b1; exp_q1.push_back(9'h1FF);
        @(posedge clk); #1 load[1] = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check($sformatf("div1_sclk_%0d", i), 32'(sclk[1]), 32'(i % 2));
            check($sformatf("div1_sdo_%0d", i), 32'(sdo[1]), 32'd1);
        end
        wait_done(1, 10);

        // LOAD held across three frame starts with DATA_IN ramping 0,1,2.
        dstart = done_cnt[0];
        @(posedge clk); #1 din0 = 9'd0; load[0] = 1'b1;
        exp_q0.push_back(9'd0); exp_q0.push_back(9'd1); exp_q0.push_back(9'd2);
        @(posedge clk); #1 din0 = 9'd1;
        wait_done(0, 100);
        @(posedge clk); #1 din0 = 9'd2;
        wait_done(0, 100);
        @(posedge clk); #1 load[0] = 1'b0;
        wait_done(0, 100);
        repeat (20) @(negedge clk);
        check("b2b_done_count", done_cnt[0] - dstart, 3);
        check("b2b_busy_run", last_run[0], 3 * 77);

        check("queue_empty_d0", exp_q0.size(), 0);
        check("queue_empty_d1", exp_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
